bht_upd_sched: RTL

BHT_UPD_SCHED -- requirements
Module: bht_upd_sched

---
 rtl/bht_upd_sched_if.sv | 36 +++
 rtl/bht_upd_sched.sv | 117 +++++++++++
 2 files changed

// File: rtl/bht_upd_sched_if.sv
// Resolve/update/invalidate signal bundle between the branch-resolution side and the BHT update scheduler.
// The scheduler connects through the slave modport; the requester and the predictor table use the master side.
`ifndef WIDTH_PC
`define WIDTH_PC 32
`endif

interface bht_upd_sched_if #(
   parameter int IDX_W = 7
);
   logic                 res_valid;
   logic [`WIDTH_PC-1:0] res_pc;
   logic                 res_wrong;
   logic                 res_ready;
   logic                 lookup_active;
   logic                 flush_req;
   logic                 upd_en;
   logic [`WIDTH_PC-1:0] upd_pc;
   logic                 upd_wrong;
   logic                 clr_en;
   logic [IDX_W-1:0]     clr_idx;
   logic                 stall_fetch;
   logic                 busy;
   logic                 flush_done;

   modport master (
      output res_valid, res_pc, res_wrong, lookup_active, flush_req,
      input  res_ready, upd_en, upd_pc, upd_wrong, clr_en, clr_idx,
             stall_fetch, busy, flush_done
   );

   modport slave (
      input  res_valid, res_pc, res_wrong, lookup_active, flush_req,
      output res_ready, upd_en, upd_pc, upd_wrong, clr_en, clr_idx,
             stall_fetch, busy, flush_done
   );
endinterface

// File: rtl/bht_upd_sched.sv
// BHT update scheduler: queues resolved branches and writes them into the table when fetch is idle or starved.
// It also sweeps the whole table clean on a flush. Define BHT_SCHED_BYPASS_EN to write an idle-cycle offer straight through.
`ifndef WIDTH_PC
`define WIDTH_PC 32
`endif

module bht_upd_sched #(
   parameter int QDEPTH     = 4,
   parameter int STARVE_MAX = 8,
   parameter int IDX_W      = 7
) (
   input  logic           clk,
   input  logic           rst,
   bht_upd_sched_if.slave bus
);
   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNT_W = $clog2(QDEPTH + 1);
   localparam int STV_W = $clog2(STARVE_MAX + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = '1;

   typedef struct packed {
      logic [`WIDTH_PC-1:0] pc;
      logic                 wrong;
   } entry_t;

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t           state;
   entry_t           queueMem [QDEPTH];
   logic [PTR_W-1:0] headPtr, tailPtr;
   logic [CNT_W-1:0] count;
   logic [STV_W-1:0] starveCnt;
   logic             stallReg, doneReg;
   logic [IDX_W-1:0] clrIdx;

   logic   isIdle, qEmpty, doPop, doPush, bypassHit;
   entry_t headEntry;

   assign isIdle    = (state == IDLE);
   assign qEmpty    = (count == '0);
   assign headEntry = queueMem[headPtr];

`ifdef BHT_SCHED_BYPASS_EN
   assign bypassHit = isIdle && !bus.flush_req && qEmpty && !bus.lookup_active && bus.res_valid;
`else
   assign bypassHit = 1'b0;
`endif

   // A flush request in IDLE wins over any same-cycle push or pop.
   assign doPop  = isIdle && !bus.flush_req && !qEmpty && (!bus.lookup_active || stallReg);
   assign doPush = bus.res_valid && bus.res_ready && !bus.flush_req && !bypassHit;

   assign bus.res_ready   = isIdle && (count < CNT_W'(QDEPTH));
   assign bus.upd_en      = doPop || bypassHit;
   assign bus.upd_pc      = bypassHit ? bus.res_pc    : headEntry.pc;
   assign bus.upd_wrong   = bypassHit ? bus.res_wrong : headEntry.wrong;
   assign bus.clr_en      = (state == FLUSH);
   assign bus.clr_idx     = clrIdx;
   assign bus.stall_fetch = stallReg;
   assign bus.busy        = !qEmpty || (state == FLUSH);
   assign bus.flush_done  = doneReg;

   // NOTE: queue storage is deliberately not reset; only count decides which slots hold live entries.
   always_ff @(posedge clk) begin
      if (doPush) queueMem[tailPtr] <= entry_t'{pc: bus.res_pc, wrong: bus.res_wrong};
   end

   // NOTE: all state here uses non-blocking assignments so every update sees the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         headPtr   <= '0;
         tailPtr   <= '0;
         count     <= '0;
         starveCnt <= '0;
         stallReg  <= 1'b0;
         doneReg   <= 1'b0;
         clrIdx    <= '0;
      end else begin
         doneReg  <= 1'b0;
         stallReg <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.flush_req) begin
                  state     <= FLUSH;
                  headPtr   <= '0;
                  tailPtr   <= '0;
                  count     <= '0;
                  starveCnt <= '0;
                  clrIdx    <= '0;
               end else begin
                  if (doPush) tailPtr <= tailPtr + PTR_W'(1);
                  if (doPop)  headPtr <= headPtr + PTR_W'(1);
                  if (doPush && !doPop)      count <= count + CNT_W'(1);
                  else if (doPop && !doPush) count <= count - CNT_W'(1);
                  // Each blocked cycle moves toward a forced write slot one cycle later.
                  if (doPop) begin
                     starveCnt <= '0;
                  end else if (!qEmpty && bus.lookup_active) begin
                     starveCnt <= starveCnt + STV_W'(1);
                     stallReg  <= (starveCnt == STV_W'(STARVE_MAX - 1));
                  end
               end
            end
            FLUSH: begin
               starveCnt <= '0;
               clrIdx    <= clrIdx + IDX_W'(1);
               if (clrIdx == LAST_IDX) begin
                  state   <= IDLE;
                  doneReg <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
